// File: rtl/finger_grip_if.sv
// Command/status bundle between Main, the tenzo stage and one finger motor controller.
// Main drives the i_* side; the controller drives the o_* side.
interface finger_grip_if;
  logic       i_close;
  logic       i_open;
  logic       i_limit1;
  logic       i_open_stop;
  logic       i_clear;
  logic       o_motor_en;
  logic       o_motor_dir;
  logic       o_pwm;
  logic [2:0] o_state;
  logic       o_gripped;
  logic       o_fault;

  modport master (
    output i_close, i_open, i_limit1, i_open_stop, i_clear,
    input  o_motor_en, o_motor_dir, o_pwm, o_state, o_gripped, o_fault
  );

  modport slave (
    input  i_close, i_open, i_limit1, i_open_stop, i_clear,
    output o_motor_en, o_motor_dir, o_pwm, o_state, o_gripped, o_fault
  );
endinterface

// File: rtl/finger_grip_ctrl.sv
// Finger motor grip sequencer: close until the debounced pressure limit, hold at reduced
// torque, open to the endstop; soft-start PWM ramp, per-move timeout, latched fault.
//
//   state     | meaning
//   IDLE    0 | motor off, waiting for a command
//   CLOSING 1 | driving closed, ramping duty, debouncing i_limit1
//   HOLD    2 | gripped, fixed HOLD_DUTY torque
//   OPENING 3 | driving open, ramping duty, waiting for the endstop
//   FAULT   4 | move timed out, motor off until i_clear
module finger_grip_ctrl #(
  parameter int PWM_BITS  = 8,
  parameter int DEBOUNCE  = 4,
  parameter int TIMEOUT   = 1000,
  parameter int RAMP_STEP = 8,
  parameter int DUTY_MAX  = 200,
  parameter int HOLD_DUTY = 64
) (
  input logic          clk,
  input logic          rst_n,
  finger_grip_if.slave bus
);

  localparam int DEB_W = $clog2(DEBOUNCE + 1);
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam logic [DEB_W-1:0]    DEB_LAST = DEB_W'(DEBOUNCE - 1);
  localparam logic [TMO_W-1:0]    TMO_LAST = TMO_W'(TIMEOUT - 1);
  localparam logic [PWM_BITS-1:0] CNT_MAX  = '1;
  localparam logic [PWM_BITS:0]   STEP_EXT = (PWM_BITS + 1)'(RAMP_STEP);
  localparam logic [PWM_BITS:0]   MAX_EXT  = (PWM_BITS + 1)'(DUTY_MAX);
  localparam logic [PWM_BITS-1:0] HOLD_D   = PWM_BITS'(HOLD_DUTY);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CLOSING = 3'd1,
    S_HOLD    = 3'd2,
    S_OPENING = 3'd3,
    S_FAULT   = 3'd4
  } state_t;

  state_t              state, state_nxt;
  logic [DEB_W-1:0]    deb_cnt, deb_nxt;
  logic [TMO_W-1:0]    tmo_cnt, tmo_nxt;
  logic [PWM_BITS-1:0] pwm_cnt, duty, duty_nxt;
  logic [PWM_BITS:0]   duty_sum;
  logic                grip_hit, tmo_hit, moving_nxt;
  logic                motor_en, motor_dir, pwm, gripped, fault;

  always_comb begin
    grip_hit   = bus.i_limit1 && (deb_cnt == DEB_LAST);
    tmo_hit    = (tmo_cnt == TMO_LAST);
    state_nxt  = state;
    case (state)
      S_IDLE: begin
        if (bus.i_close && !bus.i_open)
          state_nxt = S_CLOSING;
        else if (bus.i_open && !bus.i_close && !bus.i_open_stop)
          state_nxt = S_OPENING;
      end
      S_CLOSING: begin
        if (bus.i_open)    state_nxt = S_OPENING;
        else if (grip_hit) state_nxt = S_HOLD;
        else if (tmo_hit)  state_nxt = S_FAULT;
      end
      S_HOLD:    if (bus.i_open) state_nxt = S_OPENING;
      S_OPENING: begin
        if (bus.i_open_stop) state_nxt = S_IDLE;
        else if (tmo_hit)    state_nxt = S_FAULT;
      end
      S_FAULT:   if (bus.i_clear) state_nxt = S_IDLE;
      default:   state_nxt = S_FAULT;
    endcase

    moving_nxt = (state_nxt == S_CLOSING) || (state_nxt == S_OPENING);

    deb_nxt = '0;
    if (state == S_CLOSING && state_nxt == S_CLOSING && bus.i_limit1)
      deb_nxt = deb_cnt + 1'b1;

    tmo_nxt = '0;
    if (moving_nxt && state_nxt == state)
      tmo_nxt = tmo_cnt + 1'b1;

    // Entering a move (including a reversal) restarts the soft-start ramp from zero.
    duty_sum = {1'b0, duty} + STEP_EXT;
    duty_nxt = '0;
    if (moving_nxt) begin
      if (state_nxt != state)
        duty_nxt = '0;
      else if (pwm_cnt == CNT_MAX)
        duty_nxt = (duty_sum > MAX_EXT) ? MAX_EXT[PWM_BITS-1:0] : duty_sum[PWM_BITS-1:0];
      else
        duty_nxt = duty;
    end else if (state_nxt == S_HOLD) begin
      duty_nxt = HOLD_D;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      deb_cnt   <= '0;
      tmo_cnt   <= '0;
      pwm_cnt   <= '0;
      duty      <= '0;
      motor_en  <= 1'b0;
      motor_dir <= 1'b0;
      gripped   <= 1'b0;
      fault     <= 1'b0;
      pwm       <= 1'b0;
    end else begin
      state     <= state_nxt;
      deb_cnt   <= deb_nxt;
      tmo_cnt   <= tmo_nxt;
      pwm_cnt   <= pwm_cnt + 1'b1;
      duty      <= duty_nxt;
      motor_en  <= (state_nxt == S_CLOSING) || (state_nxt == S_HOLD) || (state_nxt == S_OPENING);
      motor_dir <= (state_nxt == S_CLOSING) || (state_nxt == S_HOLD);
      gripped   <= (state_nxt == S_HOLD);
      fault     <= (state_nxt == S_FAULT);
      pwm       <= motor_en && (pwm_cnt < duty);
    end
  end

  assign bus.o_motor_en  = motor_en;
  assign bus.o_motor_dir = motor_dir;
  assign bus.o_pwm       = pwm;
  assign bus.o_state     = state;
  assign bus.o_gripped   = gripped;
  assign bus.o_fault     = fault;

endmodule
